// File: rtl/fpu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_issue_ctrl_if
//  Purpose  : Bundles the op-request, ALU drive/return and result handshake
//             signals of the FP add/sub issue controller.
//  Modports : slave  - the issue controller (fpu_issue_ctrl)
//             master - the surrounding system (op source, ALU, result sink)
//  Signals  : IN_*      op request (valid/ready) with operands, opcode, tag
//             ALU_*     registered operands/opcode to the ALU, ALU_OUT back
//             RES_*     in-order result FIFO head (valid/ready) with tag
//             ILLEGAL*  one-cycle pulse + tag for a dropped illegal opcode
//             BUSY      any op anywhere in the block
//  Revision : 1.0  initial release
// ============================================================================
interface fpu_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [31:0]      IN_A;
    logic [31:0]      IN_B;
    logic [2:0]       IN_CTRL;
    logic [TAG_W-1:0] IN_TAG;
    logic [31:0]      ALU_A;
    logic [31:0]      ALU_B;
    logic [2:0]       ALU_CTRL;
    logic [31:0]      ALU_OUT;
    logic             RES_VALID;
    logic             RES_READY;
    logic [31:0]      RES_DATA;
    logic [TAG_W-1:0] RES_TAG;
    logic             ILLEGAL;
    logic [TAG_W-1:0] ILLEGAL_TAG;
    logic             BUSY;

    modport slave (
        input  IN_VALID, IN_A, IN_B, IN_CTRL, IN_TAG, ALU_OUT, RES_READY,
        output IN_READY, ALU_A, ALU_B, ALU_CTRL, RES_VALID, RES_DATA, RES_TAG,
               ILLEGAL, ILLEGAL_TAG, BUSY
    );

    modport master (
        output IN_VALID, IN_A, IN_B, IN_CTRL, IN_TAG, ALU_OUT, RES_READY,
        input  IN_READY, ALU_A, ALU_B, ALU_CTRL, RES_VALID, RES_DATA, RES_TAG,
               ILLEGAL, ILLEGAL_TAG, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_issue_ctrl
//  Purpose  : Issue stage for a pipelined, non-stallable FP add/sub ALU.
//             Buffers ops, issues them with a mandatory one-cycle operand
//             hold, tracks in-flight ops over the fixed ALU latency and
//             captures ALU results with their tags into an in-order FIFO.
//             Credit-based issue keeps in-flight + stored results within
//             the result FIFO depth, so a result always has a slot.
//  Ports    : FPUCLK  clock (rising edge)
//             RST     synchronous reset, active high
//             bus     fpu_issue_ctrl_if.slave (op in, ALU drive/return,
//                     result out, illegal-op report, busy)
//  Revision : 1.0  initial release
// ============================================================================
module fpu_issue_ctrl #(
    parameter int IN_DEPTH  = 4,
    parameter int RES_DEPTH = 4,
    parameter int ALU_LAT   = 4,
    parameter int TAG_W     = 4
) (
    input  logic                   FPUCLK,
    input  logic                   RST,
    fpu_issue_ctrl_if.slave        bus
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int RES_AW = $clog2(RES_DEPTH);
    localparam int INF_W  = $clog2(ALU_LAT + 1);
    localparam int SUM_W  = 8;
    localparam int ENT_W  = 1 + 32 + 32 + TAG_W;   // {sub, a, b, tag}
    localparam int RENT_W = 32 + TAG_W;            // {data, tag}

    localparam logic [2:0] C_OP_ADD = 3'b000;
    localparam logic [2:0] C_OP_SUB = 3'b001;
    localparam logic [2:0] C_OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [ENT_W-1:0]  r_in_mem [IN_DEPTH];
    logic [IN_AW-1:0]  r_in_wr;
    logic [IN_AW-1:0]  r_in_rd;
    logic [IN_AW:0]    r_in_count;

    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_in_legal;
    logic              w_in_push;
    logic              w_in_pop;
    logic [ENT_W-1:0]  w_in_head;

    // Ready is deliberately not pop-aware: a full FIFO refuses even when
    // the head is leaving this cycle.
    assign w_in_ready = !RST && (r_in_count < (IN_AW+1)'(IN_DEPTH));
    assign w_in_fire  = bus.IN_VALID && w_in_ready;
    assign w_in_legal = (bus.IN_CTRL == C_OP_ADD) || (bus.IN_CTRL == C_OP_SUB);
    assign w_in_push  = w_in_fire && w_in_legal;
    assign w_in_head  = r_in_mem[r_in_rd];

    always_ff @(posedge FPUCLK) begin
        if (w_in_push) begin
            r_in_mem[r_in_wr] <= {bus.IN_CTRL[0], bus.IN_A, bus.IN_B, bus.IN_TAG};
        end
    end

    always_ff @(posedge FPUCLK) begin
        if (RST) begin
            r_in_wr    <= '0;
            r_in_rd    <= '0;
            r_in_count <= '0;
        end else begin
            if (w_in_push) r_in_wr <= r_in_wr + IN_AW'(1);
            if (w_in_pop)  r_in_rd <= r_in_rd + IN_AW'(1);
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_count <= r_in_count + (IN_AW+1)'(1);
                2'b01:   r_in_count <= r_in_count - (IN_AW+1)'(1);
                default: r_in_count <= r_in_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Credit check and issue FSM
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [2:0]          r_alu_ctrl;
    logic [31:0]         r_alu_a;
    logic [31:0]         r_alu_b;
    logic [TAG_W-1:0]    r_iss_tag;
    logic [ALU_LAT-1:0]  r_infl;
    logic [RES_AW:0]     r_res_count;

    logic [INF_W-1:0]    w_infl_cnt;
    logic                w_credit_ok;
    logic                w_issue;

    always_comb begin
        w_infl_cnt = '0;
        for (int i = 0; i < ALU_LAT; i++) begin
            w_infl_cnt = w_infl_cnt + INF_W'(r_infl[i]);
        end
    end

    // A pop of the result FIFO this cycle is not credited back until the
    // next cycle, keeping the decision purely registered-state based.
    assign w_credit_ok = (SUM_W'(r_res_count) + SUM_W'(w_infl_cnt)) < SUM_W'(RES_DEPTH);

    // ISSUE is always followed by HOLD, so an op is never issued in the
    // cycle right after another: the ALU re-reads A/B in its 2nd stage.
    assign w_issue  = (r_state != S_ISSUE) && (r_in_count != '0) && w_credit_ok;
    assign w_in_pop = w_issue;

    always_ff @(posedge FPUCLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_alu_ctrl <= C_OP_NOP;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_iss_tag  <= '0;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    r_state    <= S_HOLD;
                    r_alu_ctrl <= C_OP_NOP;
                end
                default: begin
                    if (w_issue) begin
                        r_state    <= S_ISSUE;
                        r_alu_ctrl <= {2'b00, w_in_head[ENT_W-1]};
                        r_alu_a    <= w_in_head[ENT_W-2 -: 32];
                        r_alu_b    <= w_in_head[TAG_W+31 -: 32];
                        r_iss_tag  <= w_in_head[TAG_W-1:0];
                    end else begin
                        r_state    <= S_IDLE;
                        r_alu_ctrl <= C_OP_NOP;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracking: bit 0 is loaded at the end of the issue cycle,
    // so the top bit marks the cycle whose ALU_OUT belongs to that op.
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] r_infl_tag [ALU_LAT];

    always_ff @(posedge FPUCLK) begin
        if (RST) begin
            r_infl <= '0;
        end else begin
            r_infl <= {r_infl[ALU_LAT-2:0], (r_state == S_ISSUE)};
        end
    end

    always_ff @(posedge FPUCLK) begin
        r_infl_tag[0] <= r_iss_tag;
        for (int i = 1; i < ALU_LAT; i++) begin
            r_infl_tag[i] <= r_infl_tag[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO (fall-through head)
    // ------------------------------------------------------------------
    logic [RENT_W-1:0] r_res_mem [RES_DEPTH];
    logic [RES_AW-1:0] r_res_wr;
    logic [RES_AW-1:0] r_res_rd;

    logic              w_res_push;
    logic              w_res_valid;
    logic              w_res_pop;
    logic [RENT_W-1:0] w_res_head;

    assign w_res_push  = r_infl[ALU_LAT-1] && !RST;
    assign w_res_valid = (r_res_count != '0);
    assign w_res_pop   = w_res_valid && bus.RES_READY;
    assign w_res_head  = r_res_mem[r_res_rd];

    always_ff @(posedge FPUCLK) begin
        if (w_res_push) begin
            r_res_mem[r_res_wr] <= {bus.ALU_OUT, r_infl_tag[ALU_LAT-1]};
        end
    end

    always_ff @(posedge FPUCLK) begin
        if (RST) begin
            r_res_wr    <= '0;
            r_res_rd    <= '0;
            r_res_count <= '0;
        end else begin
            if (w_res_push) r_res_wr <= r_res_wr + RES_AW'(1);
            if (w_res_pop)  r_res_rd <= r_res_rd + RES_AW'(1);
            case ({w_res_push, w_res_pop})
                2'b10:   r_res_count <= r_res_count + (RES_AW+1)'(1);
                2'b01:   r_res_count <= r_res_count - (RES_AW+1)'(1);
                default: r_res_count <= r_res_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Illegal-op report
    // ------------------------------------------------------------------
    logic             r_illegal;
    logic [TAG_W-1:0] r_ill_tag;

    always_ff @(posedge FPUCLK) begin
        if (RST) begin
            r_illegal <= 1'b0;
            r_ill_tag <= '0;
        end else begin
            r_illegal <= w_in_fire && !w_in_legal;
            if (w_in_fire && !w_in_legal) r_ill_tag <= bus.IN_TAG;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.IN_READY    = w_in_ready;
    assign bus.ALU_CTRL    = r_alu_ctrl;
    assign bus.ALU_A       = r_alu_a;
    assign bus.ALU_B       = r_alu_b;
    assign bus.RES_VALID   = w_res_valid;
    assign bus.RES_DATA    = w_res_head[RENT_W-1 -: 32];
    assign bus.RES_TAG     = w_res_head[TAG_W-1:0];
    assign bus.ILLEGAL     = r_illegal;
    assign bus.ILLEGAL_TAG = r_ill_tag;
    assign bus.BUSY        = (r_in_count != '0) || (r_state != S_IDLE) ||
                             (|r_infl) || (r_res_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_issue_ctrl
//  Purpose  : Directed self-checking bench for fpu_issue_ctrl with a small
//             4-cycle ALU model that re-reads A/B in its second stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpu_issue_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_issue_ctrl_if #(.TAG_W(4)) bus ();

    fpu_issue_ctrl #(
        .IN_DEPTH (4),
        .RES_DEPTH(4),
        .ALU_LAT  (4),
        .TAG_W    (4)
    ) u_dut (
        .FPUCLK(clk),
        .RST   (rst),
        .bus   (bus)
    );

    // ---------------- op table with hand-computed results ----------------
    logic [2:0]  op_c [10];
    logic [31:0] op_a [10];
    logic [31:0] op_b [10];
    logic [31:0] op_r [10];

    function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case ({c, a, b})
            {3'b000, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {3'b000, 32'h40000000, 32'h40000000}: return 32'h40800000;
            {3'b001, 32'h40000000, 32'h3F800000}: return 32'h3F800000;
            {3'b000, 32'h3F800000, 32'h40000000}: return 32'h40400000;
            {3'b001, 32'h40400000, 32'h3F800000}: return 32'h40000000;
            {3'b000, 32'h3F000000, 32'h3F000000}: return 32'h3F800000;
            {3'b001, 32'h40800000, 32'h3F800000}: return 32'h40400000;
            {3'b000, 32'h40800000, 32'h40800000}: return 32'h41000000;
            {3'b001, 32'h3F800000, 32'h3F000000}: return 32'h3F000000;
            {3'b000, 32'h40400000, 32'h3F800000}: return 32'h40800000;
            default:                              return 32'hBAD2BAD2;
        endcase
    endfunction

    // ---------------- ALU model (no reset, 4-cycle latency) ----------------
    logic        s1_v = 1'b0;
    logic [2:0]  s1_c = 3'b111;
    logic [31:0] s1_a = '0, s1_b = '0;
    logic [31:0] s2_r = 32'hBAD0BAD0, s3_r = 32'hBAD0BAD0, s4_r = 32'hBAD0BAD0;

    always @(posedge clk) begin
        s1_v <= (bus.ALU_CTRL == 3'b000) || (bus.ALU_CTRL == 3'b001);
        s1_c <= bus.ALU_CTRL;
        s1_a <= bus.ALU_A;
        s1_b <= bus.ALU_B;
        s2_r <= !s1_v ? 32'hBAD0BAD0 :
                ((bus.ALU_A == s1_a) && (bus.ALU_B == s1_b)) ? alu_ref(s1_c, s1_a, s1_b) : 32'hBAD1BAD1;
        s3_r <= s2_r;
        s4_r <= s3_r;
    end
    assign bus.ALU_OUT = s4_r;

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- monitor (negedge sampling) ----------------
    int          iss_log[$];
    int          res_cyc[$];
    logic [31:0] res_dat[$];
    logic [3:0]  res_tag[$];
    int          adj_cnt  = 0;
    int          hold_cnt = 0;
    logic        prev_iss = 1'b0;
    logic [31:0] prev_a = '0, prev_b = '0;

    always @(negedge clk) begin
        if (bus.ALU_CTRL != 3'b111) iss_log.push_back(cyc);
        if (prev_iss) begin
            if (bus.ALU_CTRL != 3'b111) adj_cnt++;
            if ((bus.ALU_A !== prev_a) || (bus.ALU_B !== prev_b)) hold_cnt++;
        end
        prev_iss = (bus.ALU_CTRL != 3'b111);
        prev_a   = bus.ALU_A;
        prev_b   = bus.ALU_B;
        if (bus.RES_VALID && bus.RES_READY) begin
            res_cyc.push_back(cyc);
            res_dat.push_back(bus.RES_DATA);
            res_tag.push_back(bus.RES_TAG);
        end
    end

    task automatic clear_logs();
        iss_log.delete();
        res_cyc.delete();
        res_dat.delete();
        res_tag.delete();
        adj_cnt  = 0;
        hold_cnt = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, output int hc);
        bit ok = 1'b0;
        hc = -1;
        bus.IN_VALID = 1'b1;
        bus.IN_CTRL  = c;
        bus.IN_A     = a;
        bus.IN_B     = b;
        bus.IN_TAG   = t;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.IN_READY) begin
                ok = 1'b1;
                hc = cyc;
                break;
            end
        end
        check_val("send_handshake", 64'(ok), 64'd1);
        @(posedge clk); #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!bus.BUSY) break;
        end
        check_val("idle_busy", 64'(bus.BUSY), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic fill8();
        int hc;
        bus.RES_READY = 1'b0;
        for (int i = 0; i < 8; i++) send(op_c[i], op_a[i], op_b[i], 4'(i), hc);
    endtask

    task automatic check_results(input string tag, input int n);
        check_val({tag, "_count"}, 64'(res_tag.size()), 64'(n));
        for (int i = 0; i < n && i < res_tag.size(); i++) begin
            check_val({tag, "_tag"},  64'(res_tag[i]), 64'(i));
            check_val({tag, "_data"}, 64'(res_dat[i]), 64'(op_r[i]));
        end
    endtask

    int c, k, n0, c_bg;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        op_c[0]=3'b000; op_a[0]=32'h3F800000; op_b[0]=32'h3F800000; op_r[0]=32'h40000000;
        op_c[1]=3'b000; op_a[1]=32'h40000000; op_b[1]=32'h40000000; op_r[1]=32'h40800000;
        op_c[2]=3'b001; op_a[2]=32'h40000000; op_b[2]=32'h3F800000; op_r[2]=32'h3F800000;
        op_c[3]=3'b000; op_a[3]=32'h3F800000; op_b[3]=32'h40000000; op_r[3]=32'h40400000;
        op_c[4]=3'b001; op_a[4]=32'h40400000; op_b[4]=32'h3F800000; op_r[4]=32'h40000000;
        op_c[5]=3'b000; op_a[5]=32'h3F000000; op_b[5]=32'h3F000000; op_r[5]=32'h3F800000;
        op_c[6]=3'b001; op_a[6]=32'h40800000; op_b[6]=32'h3F800000; op_r[6]=32'h40400000;
        op_c[7]=3'b000; op_a[7]=32'h40800000; op_b[7]=32'h40800000; op_r[7]=32'h41000000;
        op_c[8]=3'b001; op_a[8]=32'h3F800000; op_b[8]=32'h3F000000; op_r[8]=32'h3F000000;
        op_c[9]=3'b000; op_a[9]=32'h40400000; op_b[9]=32'h3F800000; op_r[9]=32'h40800000;

        bus.IN_VALID  = 1'b0;
        bus.IN_A      = '0;
        bus.IN_B      = '0;
        bus.IN_CTRL   = 3'b000;
        bus.IN_TAG    = '0;
        bus.RES_READY = 1'b1;

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready",    64'(bus.IN_READY),    64'd0);
        check_val("rst_alu_ctrl",    64'(bus.ALU_CTRL),    64'd7);
        check_val("rst_alu_a",       64'(bus.ALU_A),       64'd0);
        check_val("rst_alu_b",       64'(bus.ALU_B),       64'd0);
        check_val("rst_res_valid",   64'(bus.RES_VALID),   64'd0);
        check_val("rst_illegal",     64'(bus.ILLEGAL),     64'd0);
        check_val("rst_illegal_tag", 64'(bus.ILLEGAL_TAG), 64'd0);
        check_val("rst_busy",        64'(bus.BUSY),        64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // ---------------- 1: single ADD latency ----------------
        clear_logs();
        send(3'b000, 32'h3F800000, 32'h3F800000, 4'd3, c);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check_val("t1_alu_ctrl",  64'(bus.ALU_CTRL),  (cyc == c + 2) ? 64'd0 : 64'd7);
            check_val("t1_res_valid", 64'(bus.RES_VALID), (cyc == c + 7) ? 64'd1 : 64'd0);
            if (cyc == c + 2) check_val("t1_alu_a", 64'(bus.ALU_A), 64'h3F800000);
            if (cyc == c + 7) begin
                check_val("t1_res_data", 64'(bus.RES_DATA), 64'h40000000);
                check_val("t1_res_tag",  64'(bus.RES_TAG),  64'd3);
            end
        end
        wait_idle();

        // ---------------- 2: four streamed SUBs ----------------
        clear_logs();
        for (int i = 0; i < 4; i++) send(3'b001, 32'h40400000, 32'h3F800000, 4'(i), c);
        wait_idle();
        check_val("t2_adjacent_issue", 64'(adj_cnt),  64'd0);
        check_val("t2_operand_hold",   64'(hold_cnt), 64'd0);
        check_val("t2_issue_count",    64'(iss_log.size()), 64'd4);
        check_val("t2_res_count",      64'(res_tag.size()), 64'd4);
        for (int i = 0; i < 4 && i < res_tag.size(); i++) begin
            check_val("t2_res_tag",  64'(res_tag[i]), 64'(i));
            check_val("t2_res_data", 64'(res_dat[i]), 64'h40000000);
            if (i > 0) check_val("t2_res_spacing", 64'(res_cyc[i] - res_cyc[i-1]), 64'd2);
        end

        // ---------------- 3: results back-pressured, credit limit ----------------
        clear_logs();
        fill8();
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_val("t3_issue_count", 64'(iss_log.size()), 64'd4);
        check_val("t3_in_ready",    64'(bus.IN_READY),   64'd0);
        check_val("t3_res_valid",   64'(bus.RES_VALID),  64'd1);
        check_val("t3_no_pop",      64'(res_tag.size()), 64'd0);
        @(posedge clk); #1;
        bus.RES_READY = 1'b1;
        wait_idle();
        check_results("t3", 8);
        check_val("t3_adjacent_issue", 64'(adj_cnt),  64'd0);
        check_val("t3_operand_hold",   64'(hold_cnt), 64'd0);

        // ---------------- 4: illegal opcode ----------------
        clear_logs();
        @(negedge clk);
        check_val("t4_in_ready", 64'(bus.IN_READY), 64'd1);
        @(posedge clk); #1;
        send(3'b010, 32'h3F800000, 32'h3F800000, 4'd5, c);
        @(negedge clk);
        check_val("t4_illegal_pulse", 64'(bus.ILLEGAL),     64'd1);
        check_val("t4_illegal_tag",   64'(bus.ILLEGAL_TAG), 64'd5);
        @(negedge clk);
        check_val("t4_illegal_clear", 64'(bus.ILLEGAL),     64'd0);
        repeat (10) @(negedge clk);
        check_val("t4_no_issue",  64'(iss_log.size()), 64'd0);
        check_val("t4_no_result", 64'(res_tag.size()), 64'd0);
        check_val("t4_busy",      64'(bus.BUSY),       64'd0);
        @(posedge clk); #1;

        // ---------------- 5: reset with ops in flight ----------------
        clear_logs();
        send(op_c[0], op_a[0], op_b[0], 4'd1, c);
        send(op_c[1], op_a[1], op_b[1], 4'd2, c);
        for (int n = 0; n < 20; n++) begin
            if (iss_log.size() >= 2) break;
            @(negedge clk);
        end
        check_val("t5_two_issued", 64'(iss_log.size()), 64'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("t5_alu_ctrl_nop", 64'(bus.ALU_CTRL), 64'd7);
        check_val("t5_alu_a_zero",   64'(bus.ALU_A),    64'd0);
        check_val("t5_busy",         64'(bus.BUSY),     64'd0);
        for (int n = 0; n < 8; n++) begin
            check_val("t5_res_valid_low", 64'(bus.RES_VALID), 64'd0);
            @(negedge clk);
        end
        check_val("t5_no_result", 64'(res_tag.size()), 64'd0);
        @(posedge clk); #1;
        send(3'b000, 32'h3F800000, 32'h3F800000, 4'd9, c);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check_val("t5_fresh_valid", 64'(bus.RES_VALID), (cyc == c + 7) ? 64'd1 : 64'd0);
            if (cyc == c + 7) begin
                check_val("t5_fresh_data", 64'(bus.RES_DATA), 64'h40000000);
                check_val("t5_fresh_tag",  64'(bus.RES_TAG),  64'd9);
            end
        end
        wait_idle();

        // ---------------- 6: both FIFOs full, push/pop overlap ----------------
        clear_logs();
        fill8();
        repeat (20) @(posedge clk); #1;
        n0 = iss_log.size();
        check_val("t6_full_issued", 64'(n0), 64'd4);
        fork
            begin
                send(op_c[8], op_a[8], op_b[8], 4'd8, c_bg);
                send(op_c[9], op_a[9], op_b[9], 4'd9, c_bg);
            end
        join_none
        bus.RES_READY = 1'b1;
        @(posedge clk); #1;
        bus.RES_READY = 1'b0;
        k = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (iss_log.size() > n0) begin
                k = iss_log[$];
                break;
            end
        end
        check_val("t6_reissue", 64'(iss_log.size()), 64'(n0 + 1));
        while (k >= 0 && cyc < k + 4) begin
            @(posedge clk); #1;
        end
        bus.RES_READY = 1'b1;            // pop coincides with capture of tag 4
        @(posedge clk); #1;
        bus.RES_READY = 1'b0;
        @(negedge clk);
        check_val("t6_popped_so_far", 64'(res_tag.size()), 64'd2);
        check_val("t6_head_valid",    64'(bus.RES_VALID),  64'd1);
        check_val("t6_head_tag",      64'(bus.RES_TAG),    64'd2);
        @(posedge clk); #1;
        bus.RES_READY = 1'b1;
        wait fork;
        wait_idle();
        check_results("t6", 10);
        check_val("t6_adjacent_issue", 64'(adj_cnt),  64'd0);
        check_val("t6_operand_hold",   64'(hold_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
